// File: rtl/uart0_tx_fifo_pkg.sv
// Shared constants and drain-FSM state encoding for the UART0 transmit buffer.
// UART_DATA_BITS must stay in step with uart_lite's character width.
package uart0_tx_fifo_pkg;

    localparam int UART_DATA_BITS = 8;
    localparam int TX_FIFO_DEPTH  = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GUARD = 2'd1,
        WAIT  = 2'd2
    } tx_fsm_t;

endpackage

// File: rtl/uart0_tx_fifo_sync_fifo.sv
// Circular-buffer FIFO: storage, pointers and registered level/full/empty; read data is combinational at rd_ptr.
// Single cycle push/pop; the caller must not push when full unless it pops in the same cycle.
module uart0_tx_fifo_sync_fifo #(
    parameter int  DEPTH = 16,
    parameter int  WIDTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_resetn,
    input  logic             i_clr,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_dat,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_pop_dat,
    output logic [CNT_W-1:0] o_count,
    output logic             o_full,
    output logic             o_empty
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_full;
    logic             r_empty;
    logic [CNT_W-1:0] w_count_nxt;

    // No reset on the array so it maps onto distributed RAM.
    always_ff @(posedge i_clk) begin
        if (i_push && !i_clr) begin
            r_mem[r_wr_ptr] <= i_push_dat;
        end
    end

    always_comb begin
        w_count_nxt = r_count;
        if (i_push && !i_pop) begin
            w_count_nxt = r_count + CNT_W'(1);
        end else if (i_pop && !i_push) begin
            w_count_nxt = r_count - CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else if (i_clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == CNT_W'(DEPTH));
            r_empty <= (w_count_nxt == '0);
        end
    end

    assign o_pop_dat = r_mem[r_rd_ptr];
    assign o_count   = r_count;
    assign o_full    = r_full;
    assign o_empty   = r_empty;

endmodule

// File: rtl/uart0_tx_fifo.sv
// UART0 TX buffer: queues firmware byte writes and drains them to uart_lite, one tx_vld pulse per tx_rdy handshake.
// Write-to-tx_vld latency 2 cycles; writes to a full FIFO are dropped and flagged in sticky overflow.
module uart0_tx_fifo
    import uart0_tx_fifo_pkg::*;
#(
    parameter int  DEPTH     = TX_FIFO_DEPTH,
    parameter int  DATA_BITS = UART_DATA_BITS,
    localparam int CNT_WL    = $clog2(DEPTH + 1)
) (
    input  logic                 i_clk,
    input  logic                 i_resetn,
    input  logic                 i_flush,
    input  logic                 i_wr_en,
    input  logic [DATA_BITS-1:0] i_wr_data,
    input  logic                 i_ovf_clr,
    input  logic                 i_tx_rdy,
    output logic                 o_tx_vld,
    output logic [DATA_BITS-1:0] o_tx_data,
    output logic [CNT_WL-1:0]    o_count,
    output logic                 o_full,
    output logic                 o_empty,
    output logic                 o_overflow
);

    tx_fsm_t              r_state;
    tx_fsm_t              w_state_nxt;
    logic                 r_tx_vld;
    logic [DATA_BITS-1:0] r_tx_data;
    logic                 r_overflow;

    logic                 w_pop;
    logic                 w_push;
    logic                 w_drop;
    logic [DATA_BITS-1:0] w_rd_dat;
    logic [CNT_WL-1:0]    w_count;
    logic                 w_full;
    logic                 w_empty;

    uart0_tx_fifo_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (DATA_BITS)
    ) u_fifo (
        .i_clk      (i_clk),
        .i_resetn   (i_resetn),
        .i_clr      (i_flush),
        .i_push     (w_push),
        .i_push_dat (i_wr_data),
        .i_pop      (w_pop),
        .o_pop_dat  (w_rd_dat),
        .o_count    (w_count),
        .o_full     (w_full),
        .o_empty    (w_empty)
    );

    // A pop in the same cycle frees the slot, so a write to a full FIFO is still taken then.
    assign w_push = i_wr_en && !i_flush && (!w_full || w_pop);
    assign w_drop = i_wr_en && !i_flush && w_full && !w_pop;

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // GUARD hides the cycle in which uart_lite may not yet have dropped tx_rdy.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        if (i_flush) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (!w_empty && i_tx_rdy) begin
                        w_pop       = 1'b1;
                        w_state_nxt = GUARD;
                    end
                end
                GUARD: begin
                    w_state_nxt = WAIT;
                end
                WAIT: begin
                    if (i_tx_rdy) begin
                        w_state_nxt = IDLE;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_tx_vld  <= 1'b0;
            r_tx_data <= '0;
        end else begin
            r_tx_vld <= w_pop;
            if (w_pop) begin
                r_tx_data <= w_rd_dat;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_overflow <= 1'b0;
        end else if (i_flush) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (i_ovf_clr) begin
            r_overflow <= 1'b0;
        end
    end

    assign o_tx_vld   = r_tx_vld;
    assign o_tx_data  = r_tx_data;
    assign o_count    = w_count;
    assign o_full     = w_full;
    assign o_empty    = w_empty;
    assign o_overflow = r_overflow;

endmodule
